ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
PS/2 keyboard receive front-end. Synchronises and deglitches the raw PS/2 clock/data lines and deserialises 11-bit device-to-host frames (start, 8 data LSB first, odd parity, stop). Valid scancode bytes are buffered in a small FIFO and presented on a valid/ready stream. Sits directly upstream of the keyboard Avalon slave, which pops bytes and raises its IRQ while out_valid is high.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before the filtered ps2_clk changes level (min 2)
TIMEOUT_CYCLES, 100000, clk cycles without a filtered falling edge mid-frame before abort (2 ms at 50 MHz)
FIFO_DEPTH, 8, byte entries, power of two, min 2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
ps2_data  in  1  raw PS/2 data pin (asynchronous)
out_data  out  8  FIFO head byte (show-ahead)
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head byte this cycle
frame_err  out  1  one-cycle pulse per rejected or aborted frame
overflow  out  1  sticky: byte dropped because FIFO full
err_clr  in  1  clears overflow
fifo_level  out  log2(FIFO_DEPTH)+1  current entry count

Behaviour:
- Reset is decided: reset_n, asynchronous, active-low; clock clk. All state clears on reset: out_valid=0, out_data=0, frame_err=0, overflow=0, fifo_level=0, FSM=IDLE, filtered clk=1, sync FFs=1. Reset mid-frame discards the partial frame.
- 2-FF synchronisers on ps2_clk and ps2_data.
- Filter: counter increments while synced clk differs from filtered clk and resets when they match. Filtered clk toggles when the count reaches FILTER_LEN-1. Shorter glitches are ignored.
- Falling edge of filtered clk = fe. On fe, the synced ps2_data is sampled.
- FSM:
  - IDLE: on fe with data=0 -> DATA, bit count=0. A data=1 start bit is ignored and the FSM stays in IDLE with no error.
  - DATA: on fe, shift the bit in LSB first. After the 8th bit -> PARITY.
  - PARITY: on fe, store the parity bit -> STOP.
  - STOP: on fe, the frame is good if stop=1 and odd parity holds over data+parity. Good frame -> push byte. Bad frame -> frame_err. Either way -> IDLE.
- Timeout: the counter resets on every fe and in IDLE. When it reaches TIMEOUT_CYCLES in DATA/PARITY/STOP -> IDLE with a frame_err pulse.
- Latency: byte pushed and out_valid high in the cycle after the clk edge that registered the stop-bit fe. frame_err is high for exactly that one cycle.
- FIFO:
  - Pop when out_valid & out_ready.
  - A push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - A push on a full FIFO without a pop drops the byte and sets overflow.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data is meaningful only while out_valid=1.
- err_clr: clears overflow next cycle. If err_clr and a new overflow event occur in the same cycle, the set wins.
- Host-to-device inhibit (clk held low) is not driven by this block. A long low clk simply triggers the timeout if it arrives mid-frame.

Optional Feature:
PS2_RX_PARITY_CHECK_EN
- Defined: parity mismatch rejects the frame (frame_err pulse, no push).
- Undefined: parity bit is sampled but ignored. Only a bad stop bit or a timeout causes frame_err. Parity logic is removed.

Test Plan:
- Send frame 0x1C (bits 0,0,0,1,1,1,0,0,0,p=0,1), 12.5 kHz PS/2 clk, out_ready=1 -> out_valid pulses one cycle with out_data=0x1C, frame_err=0.
- Same frame with parity=1 (macro defined) -> frame_err one pulse, out_valid stays 0. Macro undefined -> 0x1C delivered.
- out_ready=0, send 9 frames 0x01..0x09 (depth 8) -> fifo_level=8, overflow=1 after 9th. Then out_ready=1 -> reads 0x01..0x08 in order, out_valid=0. err_clr -> overflow=0.
- Start + 3 data bits, then clk held high for TIMEOUT_CYCLES+10 -> single frame_err pulse, FSM IDLE. Next full frame 0xF0 received correctly.
- 3-cycle low glitches on ps2_clk mid-frame (FILTER_LEN=8) -> no extra bits, frame 0x5A received intact. Assert reset_n low mid-frame -> all outputs 0, next frame received cleanly.
- FIFO full, out_ready=1 in the same cycle a new byte completes -> byte accepted, fifo_level stays 8, overflow stays 0.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receive front-end: pin synchronisers, clock deglitch filter, frame
// deserialiser and byte FIFO. Define PS2_RX_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);
    localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fe;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          frame_err_q, frame_err_d;
    logic          frame_ok;
    logic          push;
`ifdef PS2_RX_PARITY_CHECK_EN
    logic          parity_q, parity_d;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          pop, push_ok;

    // The filtered clock only moves after FILTER_LEN consecutive differing samples.
    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        data_s1_d  = ps2_data;
        data_s2_d  = data_s1_q;
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        fe         = 1'b0;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_clk_d = ~filt_clk_q;
                fe         = filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

`ifdef PS2_RX_PARITY_CHECK_EN
    assign frame_ok = data_s2_q && (^{shift_q, parity_q});
`else
    assign frame_ok = data_s2_q;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
        parity_d    = parity_q;
`endif
        if (state_q == IDLE || fe) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fe && !data_s2_q) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fe) begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fe) begin
`ifdef PS2_RX_PARITY_CHECK_EN
                    parity_d = data_s2_q;
`endif
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fe) begin
                    state_d = IDLE;
                    if (frame_ok) begin
                        push = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled frame is abandoned; an edge in the same cycle keeps it alive.
        if (state_q != IDLE && !fe && to_cnt_q == TO_LIMIT) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            to_cnt_d    = '0;
        end
    end

    // A full FIFO still accepts a byte when the consumer pops in the same cycle.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        pop        = (count_q != '0) && out_ready;
        push_ok    = push && ((count_q != FULL_LVL) || pop);

        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (err_clr) begin
            overflow_d = 1'b0;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            data_s1_q   <= 1'b1;
            data_s2_q   <= 1'b1;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
            parity_q    <= 1'b0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            data_s1_q   <= data_s1_d;
            data_s2_q   <= data_s2_d;
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            frame_err_q <= frame_err_d;
`ifdef PS2_RX_PARITY_CHECK_EN
            parity_q    <= parity_d;
`endif
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign fifo_level = count_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: frame vector table plus FIFO, timeout, glitch
// and reset sequences; received bytes are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int FIFO_DEPTH     = 8;
    localparam int SETUP          = 20;
    localparam int HALF_BIT       = 40;
`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overflow;
    logic       err_clr;
    logic [3:0] fifo_level;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         valid_cycles = 0;
    int         err_pulses = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] data;
        bit         flip_par;
        logic       stop_bit;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t vecs [6];

    ps2_rx_fifo #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_clr    (err_clr),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_mis++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard side: every accepted byte must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) valid_cycles++;
        if (frame_err === 1'b1) err_pulses++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", out_data);
            end else begin
                check("rx_byte", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // One PS/2 bit; ready_pulse raises out_ready for the single cycle in which the
    // falling edge of this bit reaches the receiver after synchroniser + filter delay.
    task automatic send_bit(input logic b, input bit glitch, input bit ready_pulse);
        ps2_data = b;
        ticks(SETUP);
        ps2_clk = 1'b0;
        for (int i = 1; i <= HALF_BIT; i++) begin
            tick();
            if (ready_pulse && i == 9)  out_ready = 1'b1;
            if (ready_pulse && i == 10) out_ready = 1'b0;
        end
        ps2_clk = 1'b1;
        ticks(12);
        if (glitch) begin
            ps2_clk = 1'b0;
            ticks(3);
            ps2_clk = 1'b1;
        end
        ticks(5);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip_par, input logic stop_bit,
                              input bit glitch, input bit ready_pulse);
        logic p;
        p = (~^d) ^ flip_par;
        send_bit(1'b0, glitch, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch, 1'b0);
        send_bit(p, glitch, 1'b0);
        send_bit(stop_bit, glitch, ready_pulse);
        ps2_data = 1'b1;
        ticks(40);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.exp_valid != 0) exp_q.push_back(v.data);
        send_frame(v.data, v.flip_par, v.stop_bit, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input int v0, input int e0,
                               input int exp_v, input int exp_e);
        check({name, "_valid_cycles"}, 32'(valid_cycles - v0), 32'(exp_v));
        check({name, "_err_pulses"}, 32'(err_pulses - e0), 32'(exp_e));
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int v0;
        int e0;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0};
        vecs[1] = '{8'hA5, 1'b0, 1'b1, 1, 0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1, 0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1, 0};
        vecs[4] = '{8'h1C, 1'b1, 1'b1, PAR_EN ? 0 : 1, PAR_EN ? 1 : 0};
        vecs[5] = '{8'h33, 1'b0, 1'b0, 0, 1};

        reset_n   = 1'b0;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        ticks(5);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        ticks(5);

        for (int i = 0; i < 6; i++) begin
            v0 = valid_cycles;
            e0 = err_pulses;
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), v0, e0, vecs[i].exp_valid, vecs[i].exp_err);
        end

        // Fill past capacity with the consumer stalled.
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k <= FIFO_DEPTH) exp_q.push_back(8'(k));
            send_frame(8'(k), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("full_level", 32'(fifo_level), 32'd8);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_head", 32'(out_data), 32'h01);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_level", 32'(fifo_level), 32'd8);

        // Pop in the very cycle a new byte lands on a full FIFO.
        exp_q.push_back(8'h0A);
        send_frame(8'h0A, 1'b0, 1'b1, 1'b0, 1'b1);
        check("pushpop_level", 32'(fifo_level), 32'd8);
        check("pushpop_overflow", 32'(overflow), 32'd0);

        out_ready = 1'b1;
        ticks(20);
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_level", 32'(fifo_level), 32'd0);

        // Stalled frame: start plus three data bits, then silence.
        e0 = err_pulses;
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        ps2_data = 1'b1;
        ticks(TIMEOUT_CYCLES + 40);
        check("timeout_err_pulses", 32'(err_pulses - e0), 32'd1);
        check("timeout_valid", 32'(out_valid), 32'd0);
        v0 = valid_cycles;
        e0 = err_pulses;
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("after_timeout", v0, e0, 1, 0);

        v0 = valid_cycles;
        e0 = err_pulses;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("glitch", v0, e0, 1, 0);

        // Leave a byte buffered and a frame half-received, then reset.
        out_ready = 1'b0;
        send_frame(8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
        check("prereset_level", 32'(fifo_level), 32'd1);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        ps2_data = 1'b1;
        reset_n  = 1'b0;
        tick();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        ticks(3);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        ticks(5);
        v0 = valid_cycles;
        e0 = err_pulses;
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("after_reset", v0, e0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
